// File: rtl/hls_fp_chn_in_rsci_mbuf.sv
// rtl/hls_fp_chn_in_rsci_mbuf.sv - multi-channel masked operand FIFO front-end for HLS fp cores
module hls_fp_chn_in_rsci_mbuf #(
    parameter int WIDTH = 17,
    parameter int NCHN  = 2,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic [NCHN*WIDTH-1:0]   chn_rsc_z,
    input  logic [NCHN-1:0]         chn_rsc_vz,
    output logic [NCHN-1:0]         chn_rsc_lz,
    input  logic [NCHN-1:0]         chn_rsci_mask,
    input  logic                    chn_rsci_oswt,
    input  logic                    core_wen,
    output logic                    chn_rsci_bawt,
    output logic                    chn_rsci_wen_comp,
    output logic [NCHN*WIDTH-1:0]   chn_rsci_d_mxwt,
    output logic [NCHN*CW-1:0]      chn_rsci_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                run;
    logic [CW-1:0]       cnt  [NCHN];
    logic [PW-1:0]       rptr [NCHN];
    logic [PW-1:0]       wptr [NCHN];
    logic [WIDTH-1:0]    mem  [NCHN][DEPTH];

    logic                active;
    logic                pop;
    logic [NCHN-1:0]     push;
    logic [NCHN-1:0]     pop_ch;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Gating with the live reset keeps every output quiet during the reset cycle itself.
    assign active = run & nvdla_core_rstn;

    always_comb begin
        chn_rsc_lz      = '0;
        chn_rsci_bawt   = active;
        chn_rsci_d_mxwt = '0;
        chn_rsci_cnt    = '0;
        push            = '0;
        for (int i = 0; i < NCHN; i++) begin
            chn_rsc_lz[i] = active & ~chn_rsci_mask[i] & (cnt[i] != CW'(DEPTH));
            push[i]       = chn_rsc_vz[i] & chn_rsc_lz[i];
            if (!chn_rsci_mask[i] && cnt[i] == '0)
                chn_rsci_bawt = 1'b0;
            if (nvdla_core_rstn && !chn_rsci_mask[i] && cnt[i] != '0)
                chn_rsci_d_mxwt[i*WIDTH +: WIDTH] = mem[i][rptr[i]];
            if (nvdla_core_rstn)
                chn_rsci_cnt[i*CW +: CW] = cnt[i];
        end
    end

    assign pop               = chn_rsci_oswt & core_wen & chn_rsci_bawt;
    assign pop_ch            = {NCHN{pop}} & ~chn_rsci_mask;
    assign chn_rsci_wen_comp = ~chn_rsci_oswt | chn_rsci_bawt;

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            run <= 1'b0;
            for (int i = 0; i < NCHN; i++) begin
                cnt[i]  <= '0;
                rptr[i] <= '0;
                wptr[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            for (int i = 0; i < NCHN; i++) begin
                if (push[i])
                    wptr[i] <= ptr_inc(wptr[i]);
                if (pop_ch[i])
                    rptr[i] <= ptr_inc(rptr[i]);
                cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop_ch[i]);
            end
        end
    end

    // Storage is deliberately unreset; heads are masked to zero while a channel is empty.
    always_ff @(posedge nvdla_core_clk) begin
        for (int i = 0; i < NCHN; i++) begin
            if (push[i])
                mem[i][wptr[i]] <= chn_rsc_z[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_hls_fp_chn_in_rsci_mbuf.sv
// tb/tb_hls_fp_chn_in_rsci_mbuf.sv - directed and randomized checks against a queue-based channel model
module tb_hls_fp_chn_in_rsci_mbuf;

    localparam int W  = 17;
    localparam int N  = 2;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N*W-1:0]  z = '0;
    logic [N-1:0]    vz = '0;
    logic [N-1:0]    lz;
    logic [N-1:0]    mask = '0;
    logic            oswt = 1'b0;
    logic            core_wen = 1'b0;
    logic            bawt;
    logic            wen_comp;
    logic [N*W-1:0]  d;
    logic [N*CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [N][$];
    bit           run_m = 1'b0;

    hls_fp_chn_in_rsci_mbuf #(.WIDTH(W), .NCHN(N), .DEPTH(D)) dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .chn_rsc_z         (z),
        .chn_rsc_vz        (vz),
        .chn_rsc_lz        (lz),
        .chn_rsci_mask     (mask),
        .chn_rsci_oswt     (oswt),
        .core_wen          (core_wen),
        .chn_rsci_bawt     (bawt),
        .chn_rsci_wen_comp (wen_comp),
        .chn_rsci_d_mxwt   (d),
        .chn_rsci_cnt      (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_lz();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++)
            r[i] = rstn && run_m && !mask[i] && (mq[i].size() < D);
        return r;
    endfunction

    function automatic logic exp_bawt();
        logic r = rstn && run_m;
        for (int i = 0; i < N; i++)
            if (!mask[i] && mq[i].size() == 0) r = 1'b0;
        return r;
    endfunction

    function automatic logic [N*W-1:0] exp_d();
        logic [N*W-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (rstn && !mask[i] && mq[i].size() > 0) r[i*W +: W] = mq[i][0];
        return r;
    endfunction

    function automatic logic [N*CW-1:0] exp_cnt();
        logic [N*CW-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (rstn) r[i*CW +: CW] = CW'(mq[i].size());
        return r;
    endfunction

    task automatic cycle();
        logic [N-1:0] pu;
        logic         po;
        pu = vz & exp_lz();
        po = oswt && core_wen && exp_bawt();
        @(posedge clk);
        if (!rstn) begin
            run_m = 1'b0;
            for (int i = 0; i < N; i++) mq[i].delete();
        end else begin
            run_m = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (po && !mask[i]) void'(mq[i].pop_front());
                if (pu[i]) mq[i].push_back(z[i*W +: W]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; vz = '0; oswt = 1'b1; core_wen = 1'b0; mask = '0;
        cycle();
        cycle();
        checks++; if (lz !== 2'b00 || bawt !== 1'b0) begin errors++; $display("FAIL reset_lz_bawt got %b/%b want 00/0", lz, bawt); end
        checks++; if (cnt !== '0 || d !== '0) begin errors++; $display("FAIL reset_cnt_d got %h/%h want 0/0", cnt, d); end
        checks++; if (wen_comp !== 1'b0) begin errors++; $display("FAIL reset_wen_comp got %b want 0", wen_comp); end
        rstn = 1'b1; oswt = 1'b0;
        #1;
        checks++; if (lz !== 2'b00 || wen_comp !== 1'b1) begin errors++; $display("FAIL release_first_cycle lz/wen_comp got %b/%b want 00/1", lz, wen_comp); end
        cycle();
        checks++; if (lz !== 2'b11 || bawt !== 1'b0 || cnt !== '0 || d !== '0) begin errors++; $display("FAIL idle_after_run got lz=%b bawt=%b cnt=%h d=%h want 11/0/0/0", lz, bawt, cnt, d); end
    endtask

    task automatic test_basic();
        z = '0; z[16:0] = 17'h1ABCD; vz = 2'b01;
        cycle();
        vz = '0; #1;
        checks++; if (cnt !== 4'b0001 || bawt !== 1'b0) begin errors++; $display("FAIL basic_one_push cnt/bawt got %b/%b want 0001/0", cnt, bawt); end
        z[33:17] = 17'h00F0F; vz = 2'b10;
        cycle();
        vz = '0; #1;
        checks++; if (bawt !== 1'b1 || d !== {17'h00F0F, 17'h1ABCD}) begin errors++; $display("FAIL basic_bundle bawt/d got %b/%h want 1/%h", bawt, d, {17'h00F0F, 17'h1ABCD}); end
        oswt = 1'b1; core_wen = 1'b1;
        cycle();
        oswt = 1'b0; core_wen = 1'b0; #1;
        checks++; if (cnt !== '0 || bawt !== 1'b0) begin errors++; $display("FAIL basic_pop cnt/bawt got %b/%b want 0000/0", cnt, bawt); end
    endtask

    task automatic test_fill();
        logic [W-1:0] v [3];
        for (int k = 0; k < 3; k++) v[k] = 17'($urandom());
        mask = 2'b10; vz = 2'b01;
        z[16:0] = v[0]; cycle();
        z[16:0] = v[1]; cycle();
        z[16:0] = v[2]; #1;
        checks++; if (lz[0] !== 1'b0 || cnt[1:0] !== 2'd2) begin errors++; $display("FAIL fill_full lz0/cnt0 got %b/%0d want 0/2", lz[0], cnt[1:0]); end
        cycle();
        checks++; if (cnt[1:0] !== 2'd2 || d[16:0] !== v[0]) begin errors++; $display("FAIL fill_hold cnt0/head got %0d/%h want 2/%h", cnt[1:0], d[16:0], v[0]); end
        oswt = 1'b1; core_wen = 1'b1; #1;
        checks++; if (lz[0] !== 1'b0) begin errors++; $display("FAIL fill_no_refill_in_pop lz0 got %b want 0", lz[0]); end
        cycle();
        oswt = 1'b0; #1;
        checks++; if (lz[0] !== 1'b1 || cnt[1:0] !== 2'd1 || d[16:0] !== v[1]) begin errors++; $display("FAIL fill_after_pop lz0/cnt0/head got %b/%0d/%h want 1/1/%h", lz[0], cnt[1:0], d[16:0], v[1]); end
        cycle();
        vz = '0; #1;
        checks++; if (cnt[1:0] !== 2'd2) begin errors++; $display("FAIL fill_third_accepted cnt0 got %0d want 2", cnt[1:0]); end
        oswt = 1'b1; cycle();
        checks++; if (d[16:0] !== v[2]) begin errors++; $display("FAIL fill_third_head got %h want %h", d[16:0], v[2]); end
        cycle();
        oswt = 1'b0; core_wen = 1'b0; mask = '0; #1;
        checks++; if (cnt !== '0) begin errors++; $display("FAIL fill_drain cnt got %b want 0000", cnt); end
    endtask

    task automatic test_stall();
        z = {17'h00123, 17'h00456}; vz = 2'b11;
        cycle();
        vz = '0; oswt = 1'b1; core_wen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (wen_comp !== 1'b1 || bawt !== 1'b1) begin errors++; $display("FAIL stall_wen_comp cyc%0d got %b/%b want 1/1", k, wen_comp, bawt); end
            cycle();
            checks++; if (cnt !== 4'b0101) begin errors++; $display("FAIL stall_no_pop cyc%0d cnt got %b want 0101", k, cnt); end
        end
        core_wen = 1'b1;
        cycle();
        core_wen = 1'b0; #1;
        checks++; if (bawt !== 1'b0 || wen_comp !== 1'b0) begin errors++; $display("FAIL stall_empty_block bawt/wen_comp got %b/%b want 0/0", bawt, wen_comp); end
        oswt = 1'b0;
    endtask

    task automatic test_mask();
        mask = 2'b10; z = '0; z[16:0] = 17'h00001; vz = 2'b01;
        cycle();
        vz = '0; #1;
        checks++; if (bawt !== 1'b1 || d[33:17] !== '0 || lz[1] !== 1'b0) begin errors++; $display("FAIL mask_bundle bawt/d1/lz1 got %b/%h/%b want 1/0/0", bawt, d[33:17], lz[1]); end
        oswt = 1'b1; core_wen = 1'b1;
        cycle();
        oswt = 1'b0; core_wen = 1'b0; #1;
        checks++; if (cnt !== '0) begin errors++; $display("FAIL mask_pop_ch0 cnt got %b want 0000", cnt); end
        mask = 2'b00; z[33:17] = 17'h00002; vz = 2'b10;
        cycle();
        vz = '0; mask = 2'b10; #1;
        checks++; if (d[33:17] !== '0 || lz[1] !== 1'b0 || bawt !== 1'b0) begin errors++; $display("FAIL mask_hidden d1/lz1/bawt got %h/%b/%b want 0/0/0", d[33:17], lz[1], bawt); end
        z[16:0] = 17'h00003; vz = 2'b01;
        cycle();
        vz = '0; oswt = 1'b1; core_wen = 1'b1;
        cycle();
        oswt = 1'b0; core_wen = 1'b0; #1;
        checks++; if (cnt !== 4'b0100) begin errors++; $display("FAIL mask_retained cnt got %b want 0100", cnt); end
        mask = 2'b00; #1;
        checks++; if (d[33:17] !== 17'h00002 || bawt !== 1'b0) begin errors++; $display("FAIL mask_unmask d1/bawt got %h/%b want 00002/0", d[33:17], bawt); end
        mask = 2'b01; oswt = 1'b1; core_wen = 1'b1;
        cycle();
        oswt = 1'b0; core_wen = 1'b0; mask = 2'b00; #1;
        checks++; if (cnt !== '0) begin errors++; $display("FAIL mask_drain cnt got %b want 0000", cnt); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] v [7];
        for (int k = 0; k < 7; k++) v[k] = 17'($urandom());
        mask = 2'b10; z = '0; z[16:0] = v[0]; vz = 2'b01;
        cycle();
        oswt = 1'b1; core_wen = 1'b1;
        for (int k = 1; k < 7; k++) begin
            z[16:0] = v[k]; #1;
            checks++; if (d[16:0] !== v[k-1] || cnt[1:0] !== 2'd1) begin errors++; $display("FAIL wrap_pair%0d head/cnt0 got %h/%0d want %h/1", k, d[16:0], cnt[1:0], v[k-1]); end
            cycle();
        end
        vz = '0; oswt = 1'b0; #1;
        checks++; if (d[16:0] !== v[6] || cnt[1:0] !== 2'd1) begin errors++; $display("FAIL wrap_last head/cnt0 got %h/%0d want %h/1", d[16:0], cnt[1:0], v[6]); end
        oswt = 1'b1; cycle();
        oswt = 1'b0; core_wen = 1'b0; mask = '0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rstn     = ($urandom_range(0, 79) != 0);
            vz       = N'($urandom());
            z        = {17'($urandom()), 17'($urandom())};
            oswt     = ($urandom_range(0, 3) != 0);
            core_wen = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mask = N'($urandom());
            #1;
            checks++; if (lz !== exp_lz()) begin errors++; $display("FAIL rand_lz cyc%0d got %b want %b", k, lz, exp_lz()); end
            checks++; if (bawt !== exp_bawt()) begin errors++; $display("FAIL rand_bawt cyc%0d got %b want %b", k, bawt, exp_bawt()); end
            checks++; if (wen_comp !== (!oswt || exp_bawt())) begin errors++; $display("FAIL rand_wen_comp cyc%0d got %b want %b", k, wen_comp, (!oswt || exp_bawt())); end
            checks++; if (d !== exp_d()) begin errors++; $display("FAIL rand_d cyc%0d got %h want %h", k, d, exp_d()); end
            checks++; if (cnt !== exp_cnt()) begin errors++; $display("FAIL rand_cnt cyc%0d got %b want %b", k, cnt, exp_cnt()); end
            for (int i = 0; i < N; i++) begin
                checks++; if (cnt[i*CW +: CW] > CW'(D)) begin errors++; $display("FAIL rand_cnt_bound ch%0d got %0d want <=%0d", i, cnt[i*CW +: CW], D); end
            end
            cycle();
        end
        rstn = 1'b1; vz = '0; oswt = 1'b0; core_wen = 1'b0; mask = '0;
    endtask

    task automatic test_reset_mid();
        rstn = 1'b0; cycle();
        rstn = 1'b1; cycle();
        z = {17'($urandom()), 17'($urandom())}; vz = 2'b11;
        cycle();
        cycle();
        vz = '0; #1;
        checks++; if (cnt !== 4'b1010 || lz !== 2'b00) begin errors++; $display("FAIL resetmid_full cnt/lz got %b/%b want 1010/00", cnt, lz); end
        rstn = 1'b0; vz = 2'b11; oswt = 1'b1; core_wen = 1'b1;
        cycle();
        rstn = 1'b1; vz = '0; oswt = 1'b0; core_wen = 1'b0; #1;
        checks++; if (cnt !== '0 || bawt !== 1'b0 || lz !== 2'b00 || d !== '0) begin errors++; $display("FAIL resetmid_cleared cnt/bawt/lz/d got %b/%b/%b/%h want 0000/0/00/0", cnt, bawt, lz, d); end
        cycle();
        checks++; if (lz !== 2'b11) begin errors++; $display("FAIL resetmid_rerun lz got %b want 11", lz); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_stall();
        test_mask();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
